// File: rtl/seg_frame_shifter_pkg.sv
// ---------------------------------------------------------------------------
// seg_shift_pkg
//
// Shared definitions for the seven-segment display frame shifter.
//   FRAME_W             : serial frame length in bits
//   SEG_W               : width of each field (red / green / LED)
//   RED_MSB/GRN_MSB/LED_MSB : MSB position of each field inside the frame
//   BIT_CNT_W           : width of the bit-position counter
//   seg_shift_state_t   : shifter FSM states
//   pack_frame()        : builds the 24-bit frame word from the three fields
// ---------------------------------------------------------------------------
package seg_shift_pkg;

  localparam int FRAME_W   = 24;
  localparam int SEG_W     = 7;
  localparam int RED_MSB   = 22;
  localparam int GRN_MSB   = 14;
  localparam int LED_MSB   = 6;
  localparam int BIT_CNT_W = 5;

  typedef logic [FRAME_W-1:0] seg_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    LATCH = 2'd3
  } seg_shift_state_t;

  // Frame layout, MSB first on the wire:
  //   {1'b0, red[6:0], 1'b0, grn[6:0], 1'b0, led[6:0]}
  // The three pad bits (23, 15, 7) stay 0 because f starts cleared.
  function automatic seg_frame_t pack_frame(input logic [SEG_W-1:0] red,
                                            input logic [SEG_W-1:0] grn,
                                            input logic [SEG_W-1:0] led);
    seg_frame_t f;
    f = '0;
    f[RED_MSB -: SEG_W] = red;
    f[GRN_MSB -: SEG_W] = grn;
    f[LED_MSB -: SEG_W] = led;
    return f;
  endfunction

endpackage

// File: rtl/seg_frame_shifter_timer.sv
// ---------------------------------------------------------------------------
// seg_phase_timer
//
// Phase tick generator for the frame shifter. Counts 0..DIV-1 and raises
// tick on the last count of each phase. restart forces the count back to 0
// so every FSM state starts a fresh phase.
//
// Parameters:
//   DIV      : cycles per phase, 1..255
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   restart  in   clear the phase count (state entry)
//   tick     out  high on the final cycle of the phase
// ---------------------------------------------------------------------------
module seg_phase_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Wrapping on tick as well as restart keeps the count bounded while the
  // FSM sits in IDLE and nothing restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg_frame_shifter.sv
// ---------------------------------------------------------------------------
// seg_frame_shifter
//
// Sequences the seven-segment clock's serial display shift register. A frame
// (7 red, 7 green, 7 LED enables) is accepted on a valid/ready handshake,
// shifted out MSB first on sclk/sdata, then committed with an slatch pulse.
//
// Optional feature, macro SEG_SHIFT_REFRESH_EN: after REFRESH_CYCLES idle
// cycles the last accepted frame is re-sent so the display recovers from
// glitches on the serial link. Without the macro frames go out only on
// acceptance.
//
// Parameters:
//   DIV            : cycles per sclk half-period and per latch width, 1..255
//   REFRESH_CYCLES : idle cycles before a refresh, 2..2^24-1
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   frame offered
//   in_ready   out  idle and able to accept a frame
//   in_red     in   [6:0] red segment enables
//   in_grn     in   [6:0] green segment enables
//   in_led     in   [6:0] discrete LED enables
//   sclk       out  serial shift clock
//   sdata      out  serial data, stable for the whole bit period
//   slatch     out  latch strobe, display captures on its rising edge
//   busy       out  high from acceptance until the latch pulse ends
//   dbg_state  out  current FSM state
// ---------------------------------------------------------------------------
module seg_frame_shifter
  import seg_shift_pkg::*;
#(
  parameter int unsigned DIV            = 4,
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEG_W-1:0] in_red,
  input  logic [SEG_W-1:0] in_grn,
  input  logic [SEG_W-1:0] in_led,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy,
  output seg_shift_state_t dbg_state
);

  // Parameter range guards, evaluated at elaboration.
  if (DIV < 1 || DIV > 255) begin : g_div_range
    $error("seg_frame_shifter: DIV must be within 1..255");
  end
  if (REFRESH_CYCLES < 2 || REFRESH_CYCLES > 32'h00FF_FFFF) begin : g_refresh_range
    $error("seg_frame_shifter: REFRESH_CYCLES must be within 2..2^24-1");
  end

  localparam logic [BIT_CNT_W-1:0] BIT_FIRST = BIT_CNT_W'(FRAME_W - 1);

  seg_shift_state_t      state_q, state_d;
  seg_frame_t            sreg_q, sreg_d;
  logic [BIT_CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic                  sclk_d, sdata_d, slatch_d;
  logic                  rdy_en_q;
  logic                  tick;
  logic                  restart;
  logic                  accept;
  logic                  refresh_go;
  logic                  launch;
  seg_frame_t            in_word;
  seg_frame_t            load_word;

  assign in_word = pack_frame(in_red, in_grn, in_led);

  // Handshake: a frame transfers on any rising edge where in_valid and
  // in_ready are both high. in_ready only rises in IDLE, so in_valid during a
  // send is simply ignored; nothing is queued. in_ready is also held low on
  // the single cycle a refresh launches; that cycle by construction has
  // in_valid low, so an offered frame is never refused because of a refresh.
  assign accept = in_valid && in_ready;

`ifdef SEG_SHIFT_REFRESH_EN
  localparam logic [FRAME_W-1:0] REFRESH_LAST = FRAME_W'(REFRESH_CYCLES - 1);

  logic [FRAME_W-1:0] refresh_cnt_q;
  seg_frame_t         shadow_q;
  logic               has_frame_q;
  logic               refresh_hit;

  assign refresh_hit = (state_q == IDLE) && has_frame_q &&
                       (refresh_cnt_q == REFRESH_LAST);
  // A newly offered frame on the refresh cycle takes priority.
  assign refresh_go  = refresh_hit && !in_valid;
  assign load_word   = accept ? in_word : shadow_q;

  // Counts idle cycles since the last latch; cleared whenever a send starts
  // and again when a latch pulse completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      shadow_q      <= '0;
      has_frame_q   <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q    <= in_word;
        has_frame_q <= 1'b1;
      end
      if (launch || (state_q == LATCH && tick)) begin
        refresh_cnt_q <= '0;
      end else if (state_q == IDLE && has_frame_q) begin
        refresh_cnt_q <= refresh_cnt_q + 1'b1;
      end
    end
  end
`else
  assign refresh_go = 1'b0;
  assign load_word  = in_word;
`endif

  assign launch    = accept || refresh_go;
  // rdy_en_q keeps in_ready low during reset and until the first clock edge
  // after reset is released.
  assign in_ready  = rdy_en_q && (state_q == IDLE) && !refresh_go;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Every state change begins a fresh DIV-cycle phase.
  assign restart = (state_d != state_q);

  seg_phase_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // State register, plus the serial outputs registered from the next state
  // so the display pins see glitch-free levels aligned with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      rdy_en_q <= 1'b0;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      slatch   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      rdy_en_q <= 1'b1;
      sclk     <= sclk_d;
      sdata    <= sdata_d;
      slatch   <= slatch_d;
    end
  end

  // Next-state logic. The register's MSB is always the bit on the wire; it
  // only shifts on the HI->LO boundary so sdata holds across a full bit.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = LO;
          sreg_d   = load_word;
          bitcnt_d = BIT_FIRST;
        end
      end
      LO: begin
        if (tick) begin
          state_d = HI;
        end
      end
      HI: begin
        if (tick) begin
          if (bitcnt_q == '0) begin
            state_d = LATCH;
          end else begin
            state_d  = LO;
            bitcnt_d = bitcnt_q - 1'b1;
            sreg_d   = {sreg_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          sreg_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    sclk_d   = 1'b0;
    sdata_d  = 1'b0;
    slatch_d = 1'b0;
    case (state_d)
      LO: begin
        sdata_d = sreg_d[FRAME_W-1];
      end
      HI: begin
        sclk_d  = 1'b1;
        sdata_d = sreg_d[FRAME_W-1];
      end
      LATCH: begin
        slatch_d = 1'b1;
      end
      default: begin
        sclk_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_frame_shifter.sv
// ---------------------------------------------------------------------------
// tb_seg_frame_shifter
//
// Two instances share the frame inputs: u_dut1 (DIV=1) and u_dut4 (DIV=4).
// Only one is out of reset at a time; the m_* nets select its outputs.
// Accepted frames push their hand-computed word into exp_q; the monitor
// rebuilds the word from sclk rising edges and pops/compares on each slatch
// rising edge.
// ---------------------------------------------------------------------------
module tb_seg_frame_shifter;

  localparam int REFRESH = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, rst4_n;
  logic       in_valid;
  logic [6:0] in_red, in_grn, in_led;

  logic       rdy1, sclk1, sdata1, slatch1, busy1;
  logic       rdy4, sclk4, sdata4, slatch4, busy4;
  logic [1:0] st1, st4;

  seg_frame_shifter #(.DIV(1), .REFRESH_CYCLES(REFRESH)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_red(in_red), .in_grn(in_grn), .in_led(in_led),
    .sclk(sclk1), .sdata(sdata1), .slatch(slatch1), .busy(busy1),
    .dbg_state(st1)
  );

  seg_frame_shifter #(.DIV(4), .REFRESH_CYCLES(REFRESH)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_red(in_red), .in_grn(in_grn), .in_led(in_led),
    .sclk(sclk4), .sdata(sdata4), .slatch(slatch4), .busy(busy4),
    .dbg_state(st4)
  );

  bit sel4 = 1'b0;
  int cur_div = 1;

  wire m_rst_n    = sel4 ? rst4_n  : rst1_n;
  wire m_in_ready = sel4 ? rdy4    : rdy1;
  wire m_sclk     = sel4 ? sclk4   : sclk1;
  wire m_sdata    = sel4 ? sdata4  : sdata1;
  wire m_slatch   = sel4 ? slatch4 : slatch1;
  wire m_busy     = sel4 ? busy4   : busy1;
  wire [1:0] m_st = sel4 ? st4     : st1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int latch_cnt = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [6:0]  r;
    logic [6:0]  g;
    logic [6:0]  l;
    logic [23:0] w;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic [23:0] cap = '0;
  int          nbits = 0;
  logic        p_sclk = 1'b0;
  logic        p_slatch = 1'b0;

  always @(negedge clk) begin
    if (!m_rst_n) begin
      cap      = '0;
      nbits    = 0;
      p_sclk   = 1'b0;
      p_slatch = 1'b0;
    end else begin
      if (m_sclk && !p_sclk) begin
        cap = {cap[22:0], m_sdata};
        nbits++;
      end
      if (m_slatch && !p_slatch) begin
        latch_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL latch_unexpected: got frame %h, required no latch", cap);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if (cap !== e || nbits != 24) begin
            errors++;
            $display("FAIL frame_word: got %h (%0d bits), required %h (24 bits)", cap, nbits, e);
          end
        end
        cap   = '0;
        nbits = 0;
      end
      p_sclk   = m_sclk;
      p_slatch = m_slatch;
    end
  end

  // ---------------- driver tasks ----------------
  // Offers vecs[idx] and waits (bounded) for acceptance. waited counts the
  // negedges spent waiting for in_ready. Returns 1 time unit after the
  // accepting edge; hold keeps in_valid high afterwards.
  task automatic offer(input int idx, input bit hold, output int waited);
    in_red   = vecs[idx].r;
    in_grn   = vecs[idx].g;
    in_led   = vecs[idx].l;
    in_valid = 1'b1;
    waited   = 0;
    #1;
    while (m_in_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (m_in_ready !== 1'b1) begin
      check("accept_timeout", 32'(m_in_ready), 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(vecs[idx].w);
      #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_busy !== 1'b0 && n < 3000);
    if (m_busy !== 1'b0) check("idle_timeout", 32'(m_busy), 0);
  endtask

  // Called at an idle negedge; counts idle negedges until busy rises.
  task automatic count_idle(output int n);
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_busy === 1'b1) break;
      n++;
    end
  endtask

  // Cycle-by-cycle expected waveform after an accept edge (k = edges since).
  task automatic trace(input logic [23:0] w);
    int e_sclk, e_sdata, e_latch, e_busy, lo_end, hi_end, p;
    bit x_sclk, x_sdata, x_latch, x_busy;
    e_sclk = 0; e_sdata = 0; e_latch = 0; e_busy = 0;
    lo_end = 48 * cur_div;
    hi_end = 49 * cur_div;
    for (int k = 0; k <= hi_end; k++) begin
      @(negedge clk);
      x_sclk = 1'b0; x_sdata = 1'b0; x_latch = 1'b0; x_busy = 1'b1;
      if (k < lo_end) begin
        p       = k / cur_div;
        x_sclk  = (p % 2) == 1;
        x_sdata = w[23 - p / 2];
      end else if (k < hi_end) begin
        x_latch = 1'b1;
      end else begin
        x_busy = 1'b0;
      end
      if (m_sclk   !== x_sclk)  e_sclk++;
      if (m_sdata  !== x_sdata) e_sdata++;
      if (m_slatch !== x_latch) e_latch++;
      if (m_busy   !== x_busy)  e_busy++;
    end
    check("sclk_trace_mismatches",   e_sclk,  0);
    check("sdata_trace_mismatches",  e_sdata, 0);
    check("slatch_trace_mismatches", e_latch, 0);
    check("busy_trace_mismatches",   e_busy,  0);
    check("ready_after_latch", 32'(m_in_ready), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited, n, busy_seen, latch_base;

    vecs[0] = '{7'h7F, 7'h00, 7'h01, 24'h7F0001};
    vecs[1] = '{7'h12, 7'h34, 7'h56, 24'h123456};
    vecs[2] = '{7'h01, 7'h40, 7'h7F, 24'h01407F};
    vecs[3] = '{7'h7F, 7'h7F, 7'h7F, 24'h7F7F7F};
    vecs[4] = '{7'h2B, 7'h19, 7'h05, 24'h2B1905};
    vecs[5] = '{7'h66, 7'h0F, 7'h3C, 24'h660F3C};
    vecs[6] = '{7'h55, 7'h2A, 7'h33, 24'h552A33};

    rst1_n = 1'b0; rst4_n = 1'b0;
    in_valid = 1'b0; in_red = '0; in_grn = '0; in_led = '0;

    repeat (3) @(negedge clk);
    check("reset_outs_dut1", {rdy1, sclk1, sdata1, slatch1, busy1, st1}, 0);
    check("reset_outs_dut4", {rdy4, sclk4, sdata4, slatch4, busy4, st4}, 0);
    rst1_n = 1'b1;
    #1;
    check("ready_low_at_release", 32'(m_in_ready), 0);
    @(negedge clk);
    check("ready_after_release", 32'(m_in_ready), 1);

    // Frame send with DIV=1, full waveform.
    offer(0, 1'b0, waited);
    trace(vecs[0].w);

    // Busy rejection: frame B held valid during A's send.
    offer(1, 1'b1, waited);
    offer(2, 1'b0, waited);
    check("reject_wait_negedges", waited, 49 * cur_div + 1);
    wait_idle();

`ifndef SEG_SHIFT_REFRESH_EN
    busy_seen = 0;
    repeat (3 * REFRESH) begin
      @(negedge clk);
      if (m_busy) busy_seen++;
    end
    check("no_refresh_without_macro", busy_seen, 0);
`endif

    // Mid-frame reset during bit 10's high phase.
    offer(3, 1'b0, waited);
    repeat (2 * 10 * cur_div + cur_div + 1) @(negedge clk);
    check("pre_reset_sclk_sdata_busy", {m_sclk, m_sdata, m_busy}, 3'b111);
    rst1_n = 1'b0;
    #1;
    check("outs_zero_in_reset", {m_in_ready, m_sclk, m_sdata, m_slatch, m_busy, m_st}, 0);
    exp_q.delete();
    latch_base = latch_cnt;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    #1;
    check("ready_low_after_release", 32'(m_in_ready), 0);
    @(negedge clk);
    check("ready_first_clock_after_release", 32'(m_in_ready), 1);
    repeat (60) @(negedge clk);
    check("no_latch_after_reset", latch_cnt - latch_base, 0);

`ifdef SEG_SHIFT_REFRESH_EN
    busy_seen = 0;
    repeat (3 * REFRESH) begin
      @(negedge clk);
      if (m_busy) busy_seen++;
    end
    check("no_refresh_before_frame", busy_seen, 0);

    offer(4, 1'b0, waited);
    wait_idle();
    exp_q.push_back(vecs[4].w);
    count_idle(n);
    check("refresh_idle_cycles", n, REFRESH);
    wait_idle();

    // Collision: new frame offered on the refresh cycle.
    repeat (REFRESH - 1) @(negedge clk);
    offer(5, 1'b0, waited);
    check("collision_accept_immediate", waited, 0);
    wait_idle();
    exp_q.push_back(vecs[5].w);
    count_idle(n);
    check("refresh_after_collision", n, REFRESH);
    wait_idle();
`endif

    // Switch to the DIV=4 instance.
    rst1_n = 1'b0;
    @(negedge clk);
    sel4 = 1'b1;
    cur_div = 4;
    rst4_n = 1'b1;
    @(negedge clk);
    check("ready_after_release_dut4", 32'(m_in_ready), 1);
    offer(6, 1'b0, waited);
    trace(vecs[6].w);

    repeat (4) @(negedge clk);
    check("expected_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
